// File: rtl/spi_master.sv
// SPI master with configurable clock polarity, phase, chip-select level and word width.
// One word per request; SCLK is derived from the system clock by a half-period divider.
module spi_master #(
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int CE_LEVEL   = 0,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  spi_done,
  output logic                  sclk,
  output logic                  ce,
  output logic                  mosi,
  input  logic                  miso
);

  localparam logic CPOL_B = (CPOL != 0);
  localparam logic CPHA_B = (CPHA != 0);
  localparam logic CE_ON  = (CE_LEVEL != 0);
  localparam int   DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int   EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state;
  state_t                state_next;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  accept;
  logic                  div_hit;
  logic                  edge_now;
  logic                  odd_edge;
  logic                  do_sample;
  logic                  do_shift;
  logic                  finish;

  // edge_cnt holds the number of SCLK edges already produced, so the edge
  // about to be produced is odd when edge_cnt is even.
  always_comb begin
    accept     = tx_valid && tx_ready;
    div_hit    = (div_cnt == DIV_LAST);
    edge_now   = ((state == SETUP) || (state == XFER)) && div_hit;
    odd_edge   = ~edge_cnt[0];
    do_sample  = edge_now && (odd_edge ^ CPHA_B);
    do_shift   = edge_now && (CPHA_B ? odd_edge : (!odd_edge && (edge_cnt != EDGE_LAST)));
    finish     = (state == HOLD) && div_hit;
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (div_hit) state_next = XFER;
      XFER:    if (edge_now && (edge_cnt == EDGE_LAST)) state_next = HOLD;
      HOLD:    if (div_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= CPOL_B;
      ce       <= ~CE_ON;
      mosi     <= 1'b0;
      tx_ready <= 1'b0;
      spi_done <= 1'b0;
      rx_data  <= '0;
    end else begin
      tx_ready <= (state_next == IDLE);
      spi_done <= finish;
      if (state == IDLE) begin
        div_cnt  <= '0;
        edge_cnt <= '0;
      end else begin
        div_cnt <= div_hit ? '0 : div_cnt + 1'b1;
        if (edge_now) edge_cnt <= edge_cnt + 1'b1;
      end
      if (edge_now) sclk <= ~sclk;
      // With CPHA=0 the MSB must already be on the line before the first edge.
      if (accept) begin
        ce   <= CE_ON;
        mosi <= CPHA_B ? 1'b0 : tx_data[DATA_WIDTH-1];
      end else if (finish) begin
        ce      <= ~CE_ON;
        mosi    <= 1'b0;
        rx_data <= rx_shift;
      end else if (do_shift) begin
        mosi <= tx_shift[DATA_WIDTH-1];
      end
    end
  end

  // Shift registers carry data only; they are reloaded on every accept.
  always_ff @(posedge clock) begin
    if (accept)        tx_shift <= CPHA_B ? tx_data : (tx_data << 1);
    else if (do_shift) tx_shift <= tx_shift << 1;
    if (accept)         rx_shift <= '0;
    else if (do_sample) rx_shift <= (rx_shift << 1) | DATA_WIDTH'(miso);
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-002 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have parameter CE_LEVEL, default 0, chip-select active level.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, bits per transfer (N).
REQ-005 SHALL have parameter CLK_DIV, default 4, system clocks per SCLK half-period; legal values are 2 or more.
REQ-006 SHALL have port clock, input, 1, sole system clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port tx_data, input, DATA_WIDTH, word to transmit.
REQ-009 SHALL have port tx_valid, input, 1, transfer request.
REQ-010 SHALL have port tx_ready, output, 1, master idle and able to accept a request.
REQ-011 SHALL have port rx_data, output, DATA_WIDTH, last received word.
REQ-012 SHALL have port spi_done, output, 1, one-cycle end-of-transfer pulse.
REQ-013 SHALL have port sclk, output, 1, SPI clock.
REQ-014 SHALL have port ce, output, 1, slave chip select.
REQ-015 SHALL have port mosi, output, 1, master out slave in.
REQ-016 SHALL have port miso, input, 1, master in slave out.

Function
REQ-017 SHALL use the states IDLE, SETUP, XFER, HOLD, with transitions IDLE->SETUP on accept, SETUP->XFER after CLK_DIV cycles, XFER->HOLD after edge 2N, HOLD->IDLE after CLK_DIV cycles.
REQ-018 SHALL accept a request only in a cycle with tx_valid=1 and tx_ready=1 (cycle 0), latching tx_data and dropping tx_ready at cycle 1.
REQ-019 SHALL ignore tx_valid while tx_ready=0, with no queuing and no effect on the transfer in progress.
REQ-020 SHALL drive ce=CE_LEVEL from cycle 1 through cycle 1+(2N+1)*CLK_DIV-1 inclusive.
REQ-021 SHALL toggle sclk at cycles 1+k*CLK_DIV for k=1..2N, giving N full SCLK periods, and hold sclk=CPOL at all other times.
REQ-022 SHALL shift data MSB first on both mosi and miso.
REQ-023 With CPHA=0, SHALL present the MSB on mosi from cycle 1, sample miso at odd edges, and update mosi to the next bit at even edges except edge 2N.
REQ-024 With CPHA=1, SHALL update mosi at odd edges (the MSB at edge 1) and sample miso at even edges.
REQ-025 SHALL sample miso as the value present on the clock edge on which sclk toggles.
REQ-026 SHALL drive mosi=0 while ce is inactive.
REQ-027 At cycle 1+(2N+1)*CLK_DIV, SHALL deassert ce, update rx_data with the N sampled bits, pulse spi_done for exactly one cycle, and raise tx_ready.
REQ-028 SHALL hold rx_data stable between spi_done pulses.
REQ-029 A request accepted in the spi_done cycle SHALL reassert ce on the next cycle, so ce is inactive for at least one cycle between transfers.
REQ-030 SHALL produce an end-to-end latency from accept to spi_done of 1+(2N+1)*CLK_DIV cycles; for N=8, CLK_DIV=4 this is 69 cycles.
REQ-031 SHALL size the divider counter to hold CLK_DIV-1 and the bit counter to hold 2N, with no wrap-around inside a transfer.

Reset
REQ-032 While reset=1, SHALL force sclk=CPOL, ce=~CE_LEVEL, mosi=0, tx_ready=0, spi_done=0, rx_data=0, state=IDLE, and clear all counters, regardless of clock.
REQ-033 SHALL raise tx_ready in the first clock cycle after reset deasserts.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer immediately with no spi_done pulse and no rx_data update.

Verification
REQ-035 With modes 0/0, N=8, CLK_DIV=4, tx_data=0xA5 and a slave model returning 0x66 SHALL yield mosi bits 1,0,1,0,0,1,0,1, 16 sclk toggles 4 cycles apart, rx_data=0x66, and spi_done at cycle 69 only.
REQ-036 With CPOL=1, CPHA=1, tx_data=0x3C and slave data 0xC3 SHALL keep sclk idling high, change mosi on falling edges and sample on rising edges, and yield rx_data=0xC3.
REQ-037 With tx_valid held high for 3 transfers of 0x11, 0x22, 0x33 SHALL complete exactly 3 transfers, each separated by exactly 1 ce-inactive cycle, with rx_data updated at each spi_done.
REQ-038 A tx_valid pulse carrying 0xFF during XFER SHALL leave the current mosi sequence unchanged and start no extra transfer.
REQ-039 Reset asserted at edge 7, held 3 cycles, then a new request of 0x5A SHALL cause an immediate return to idle levels, no spi_done pulse, rx_data=0, and a correct subsequent transfer.
REQ-040 Looping back to a spi_slave instance of the same parameters returning 0x66 while sending 0x88 SHALL yield rx_data=0x66 at the master and 0x88 received at the slave.
